// File: rtl/rx_ctrl_logic.sv
// rx_ctrl_logic: receive-side LP control decoder for a C-PHY slave lane.
// Synchronizes the asynchronous LP receiver levels A/B/C, optionally
// deglitches them, decodes them into the 2-bit LP control code and tracks
// the LP entry sequences (HS request, bridge, escape entry) in an FSM.
//
// Build option: define RX_CTRL_GLITCH_FILTER_EN to build the stable-sample
// glitch filter (FILTER_CYCLES). Without it every synchronized triple is
// decoded directly through one register.
//
// Ports:
//   clk         lane clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   A, B, C     LP receiver outputs, asynchronous to clk
//   RX_Ctrl_In  decoded, filtered line code (00 stop, 01 rqst, 10 bridge, 11 lp rqst)
//   Code_Valid  RX_Ctrl_In holds an accepted, legal code
//   Stop_State  FSM in STOP
//   HS_En       HS receiver enable
//   Esc_Mode    escape mode active
//   LP_Err      FSM in ERR, level-held
module rx_ctrl_logic #(
`ifdef RX_CTRL_GLITCH_FILTER_EN
    parameter int unsigned FILTER_CYCLES  = 4,
`endif
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [1:0] RX_Ctrl_In,
    output logic       Code_Valid,
    output logic       Stop_State,
    output logic       HS_En,
    output logic       Esc_Mode,
    output logic       LP_Err
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // The edge that moves the FSM into BRIDGE already counts as one settle
    // cycle of the bridge code, so HS is entered SETTLE_CYCLES edges after
    // the code update.
    localparam logic [SET_W-1:0] SETTLE_LAST =
        SET_W'((SETTLE_CYCLES > 1) ? (SETTLE_CYCLES - 2) : 0);
    localparam logic [SET_W-1:0] SETTLE_MAX  = SET_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        WAIT_STOP,
        STOP,
        HS_RQST,
        BRIDGE,
        HS,
        ESC_ENTRY,
        ESC,
        ERR
    } state_t;

    // {legal, code} decode of a line triple {A,B,C}
    function automatic logic [2:0] decode(input logic [2:0] t);
        case (t)
            3'b111:  decode = 3'b100;
            3'b001:  decode = 3'b101;
            3'b000:  decode = 3'b110;
            3'b100:  decode = 3'b111;
            default: decode = 3'b000;
        endcase
    endfunction

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] held;
    logic       accept_c;
    logic [2:0] dec_c;
    logic       code_ev;
    logic       ill_ev;

    state_t             state;
    state_t             state_nxt;
    logic [SET_W-1:0]   settle_cnt;
    logic [TO_W-1:0]    dwell_cnt;
    logic               settle_done_c;
    logic               timeout_c;

    // Two-flop synchronizer per line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {A, B, C};
            sync2 <= sync1;
        end
    end

`ifdef RX_CTRL_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_CYCLES);

    logic [FLT_W-1:0] run_cnt;
    logic [FLT_W-1:0] run_nxt;

    // Run length of identical samples; accept once when it first hits the limit
    always_comb begin
        run_nxt  = run_cnt;
        accept_c = 1'b0;
        if (sync2 != held) begin
            run_nxt = FLT_W'(1);
        end else if (run_cnt != FLT_MAX) begin
            run_nxt = run_cnt + FLT_W'(1);
        end
        accept_c = (run_nxt == FLT_MAX) && ((run_cnt != FLT_MAX) || (sync2 != held));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held    <= 3'b000;
            run_cnt <= '0;
        end else begin
            held    <= sync2;
            run_cnt <= run_nxt;
        end
    end
`else
    // Unfiltered: any change of the synchronized triple is accepted directly
    assign accept_c = (sync2 != held);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= 3'b000;
        end else begin
            held <= sync2;
        end
    end
`endif

    assign dec_c = decode(sync2);

    // Code register plus one-cycle event strobes for the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RX_Ctrl_In <= 2'b10;
            Code_Valid <= 1'b0;
            code_ev    <= 1'b0;
            ill_ev     <= 1'b0;
        end else begin
            code_ev <= 1'b0;
            ill_ev  <= 1'b0;
            if (accept_c) begin
                if (dec_c[2]) begin
                    RX_Ctrl_In <= dec_c[1:0];
                    Code_Valid <= 1'b1;
                    code_ev    <= !Code_Valid || (dec_c[1:0] != RX_Ctrl_In);
                end else begin
                    Code_Valid <= 1'b0;
                    ill_ev     <= 1'b1;
                end
            end
        end
    end

    assign settle_done_c = (settle_cnt >= SETTLE_LAST);
    assign timeout_c     = (dwell_cnt >= TO_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; events take priority over settle and timeout
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_STOP: begin
                if (code_ev && (RX_Ctrl_In == 2'b00)) state_nxt = STOP;
            end
            STOP: begin
                if (ill_ev) begin
                    state_nxt = ERR;
                end else if (code_ev) begin
                    case (RX_Ctrl_In)
                        2'b01:   state_nxt = HS_RQST;
                        2'b10:   state_nxt = ERR;
                        2'b11:   state_nxt = ERR;
                        default: state_nxt = STOP;
                    endcase
                end
            end
            HS_RQST: begin
                if (ill_ev) begin
                    state_nxt = ERR;
                end else if (code_ev) begin
                    case (RX_Ctrl_In)
                        2'b10:   state_nxt = BRIDGE;
                        2'b00:   state_nxt = STOP;
                        2'b11:   state_nxt = ERR;
                        default: state_nxt = HS_RQST;
                    endcase
                end else if (timeout_c) begin
                    state_nxt = ERR;
                end
            end
            BRIDGE: begin
                if (ill_ev) begin
                    state_nxt = ERR;
                end else if (code_ev) begin
                    case (RX_Ctrl_In)
                        2'b11:   state_nxt = ESC_ENTRY;
                        2'b00:   state_nxt = STOP;
                        2'b01:   state_nxt = ERR;
                        default: state_nxt = BRIDGE;
                    endcase
                end else if (settle_done_c) begin
                    state_nxt = HS;
                end
            end
            ESC_ENTRY: begin
                if (ill_ev) begin
                    state_nxt = ERR;
                end else if (code_ev) begin
                    case (RX_Ctrl_In)
                        2'b10:   state_nxt = ESC;
                        2'b00:   state_nxt = STOP;
                        2'b01:   state_nxt = ERR;
                        default: state_nxt = ESC_ENTRY;
                    endcase
                end else if (timeout_c) begin
                    state_nxt = ERR;
                end
            end
            HS, ESC, ERR: begin
                if (code_ev && (RX_Ctrl_In == 2'b00)) state_nxt = STOP;
            end
            default: state_nxt = WAIT_STOP;
        endcase
    end

    // Settle and dwell counters: cleared on any state change, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            dwell_cnt  <= '0;
        end else if (state_nxt != state) begin
            settle_cnt <= '0;
            dwell_cnt  <= '0;
        end else begin
            if ((state == BRIDGE) && (settle_cnt != SETTLE_MAX)) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (((state == HS_RQST) || (state == ESC_ENTRY)) && (dwell_cnt != TO_MAX)) begin
                dwell_cnt <= dwell_cnt + TO_W'(1);
            end
        end
    end

    // Registered state decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stop_State <= 1'b0;
            HS_En      <= 1'b0;
            Esc_Mode   <= 1'b0;
            LP_Err     <= 1'b0;
        end else begin
            Stop_State <= (state == STOP);
            HS_En      <= (state == HS);
            Esc_Mode   <= (state == ESC);
            LP_Err     <= (state == ERR);
        end
    end

endmodule

// File: tb/tb_rx_ctrl_logic.sv
// Directed bench for rx_ctrl_logic. Observed vector layout:
// {RX_Ctrl_In[1:0], Code_Valid, Stop_State, HS_En, Esc_Mode, LP_Err}
module tb_rx_ctrl_logic;

`ifdef RX_CTRL_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 64;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       C;
    logic [1:0] RX_Ctrl_In;
    logic       Code_Valid;
    logic       Stop_State;
    logic       HS_En;
    logic       Esc_Mode;
    logic       LP_Err;

    int total = 0;
    int bad   = 0;
    int hs_cycles = 0;
    int hs_snap;

    rx_ctrl_logic dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .C          (C),
        .RX_Ctrl_In (RX_Ctrl_In),
        .Code_Valid (Code_Valid),
        .Stop_State (Stop_State),
        .HS_En      (HS_En),
        .Esc_Mode   (Esc_Mode),
        .LP_Err     (LP_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (HS_En) hs_cycles <= hs_cycles + 1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input logic [2:0] t);
        {A, B, C} = t;
    endtask

    task automatic chk_all(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {RX_Ctrl_In, Code_Valid, Stop_State, HS_En, Esc_Mode, LP_Err};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_line(3'b111);
        wait_n(3);
        chk_all("reset_state", 7'b10_0_0000);
        rst_n = 1'b1;

        // Power-up: 111 held reaches STOP
        wait_n(LAT - 1);
        chk_all("boot_before_code", 7'b10_0_0000);
        wait_n(1);
        chk_all("boot_code", 7'b00_1_0000);
        wait_n(1);
        chk_all("boot_state_lag", 7'b00_1_0000);
        wait_n(1);
        chk_all("boot_stop", 7'b00_1_1000);

        // HS entry
        set_line(3'b001);
        wait_n(LAT + 2);
        chk_all("hs_rqst", 7'b01_1_0000);
        set_line(3'b000);
        wait_n(LAT + SETTLE);
        chk_all("bridge_pre_hs", 7'b10_1_0000);
        wait_n(1);
        chk_all("hs_en_rise", 7'b10_1_0100);
        set_line(3'b111);
        wait_n(LAT + 1);
        chk_all("hs_exit_lag", 7'b00_1_0100);
        wait_n(1);
        chk_all("hs_exit_stop", 7'b00_1_1000);

        // Escape entry, HS must never assert
        hs_snap = hs_cycles;
        set_line(3'b001);
        wait_n(LAT + 2);
        set_line(3'b000);
        wait_n(6);
        set_line(3'b100);
        wait_n(6);
        set_line(3'b000);
        wait_n(LAT + 2);
        chk_all("esc_mode", 7'b10_1_0010);
        chk_int("esc_no_hs", hs_cycles, hs_snap);
        set_line(3'b111);
        wait_n(LAT + 2);
        chk_all("esc_exit_stop", 7'b00_1_1000);

        // Illegal triple during HS_RQST
        set_line(3'b001);
        wait_n(LAT + 2);
        chk_all("ill_rqst", 7'b01_1_0000);
        set_line(3'b110);
        wait_n(LAT);
        chk_all("ill_code_invalid", 7'b01_0_0000);
        wait_n(2);
        chk_all("ill_err", 7'b01_0_0001);
        set_line(3'b111);
        wait_n(LAT);
        chk_all("err_exit_lag", 7'b00_1_0001);
        wait_n(2);
        chk_all("err_exit_stop", 7'b00_1_1000);

`ifdef RX_CTRL_GLITCH_FILTER_EN
        // Short pulses below the filter length are absorbed
        set_line(3'b001);
        wait_n(2);
        set_line(3'b111);
        wait_n(12);
        chk_all("glitch_2cyc", 7'b00_1_1000);
        set_line(3'b001);
        wait_n(3);
        set_line(3'b111);
        wait_n(12);
        chk_all("glitch_3cyc", 7'b00_1_1000);
`endif

        // HS_RQST timeout
        set_line(3'b001);
        wait_n(60);
        chk_all("to_early", 7'b01_1_0000);
        wait_n(LAT + TIMEOUT + 1 - 60);
        chk_all("to_edge_minus1", 7'b01_1_0000);
        wait_n(1);
        chk_all("to_err", 7'b01_1_0001);
        set_line(3'b111);
        wait_n(LAT + 2);
        chk_all("to_exit_stop", 7'b00_1_1000);

        // Async reset while in HS
        set_line(3'b001);
        wait_n(LAT + 2);
        set_line(3'b000);
        wait_n(LAT + SETTLE + 3);
        chk_all("rst_pre_hs", 7'b10_1_0100);
        rst_n = 1'b0;
        #1;
        chk_all("rst_async_clear", 7'b10_0_0000);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(LAT + 4);
`ifdef RX_CTRL_GLITCH_FILTER_EN
        chk_all("rst_wait_stop", 7'b10_1_0000);
`else
        chk_all("rst_wait_stop", 7'b10_0_0000);
`endif
        set_line(3'b111);
        wait_n(LAT + 1);
        chk_all("rst_restop_lag", 7'b00_1_0000);
        wait_n(1);
        chk_all("rst_restop", 7'b00_1_1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
